// File: rtl/adder_pkg.sv
// Shared constants and beat type for the adder datapath.
package adder_pkg;

  localparam int DATAW = 128;

  typedef struct packed {
    logic             last;
    logic [DATAW-1:0] data;
  } beat_t;

  localparam int BEATW = $bits(beat_t);

endpackage

// File: rtl/adder_client_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is read straight off registered storage.
module adder_client_fifo
  import adder_pkg::*;
#(
  parameter int WIDTH = BEATW,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Wrap bit differs with equal index only when the buffer is full.
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign level = level_r;
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Full refuses a write even when the head leaves in the same cycle.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Entry storage, written at the write pointer.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ONE;
      end
      unique case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + ONE;
        2'b01:   level_r <= level_r - ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/adder_client.sv
// Host-side feeder for the adder: buffers addends and streams them out over AXI-Stream.
module adder_client
  import adder_pkg::*;
#(
  parameter int DATAW      = adder_pkg::DATAW,
  parameter int FIFO_DEPTH = 8,
  parameter int CNTW       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          client_valid,
  input  logic [DATAW-1:0]              client_data,
  input  logic                          client_last,
  output logic                          client_ready,
  output logic                          axis_adder_interface_tvalid,
  output logic [DATAW-1:0]              axis_adder_interface_tdata,
  output logic                          axis_adder_interface_tlast,
  input  logic                          axis_adder_interface_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNTW-1:0]               beats_sent,
  output logic                          txn_done
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  beat_t            wbeat_s;
  beat_t            rbeat_s;
  logic [BEATW-1:0] rdata_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [CNTW-1:0]  beats_sent_r;
  logic             txn_done_r;

  // tvalid comes only from occupancy, never from tready.
  assign client_ready                = rst && !full_s;
  assign axis_adder_interface_tvalid = rst && !empty_s;
  assign push_s = client_valid && client_ready;
  assign pop_s  = axis_adder_interface_tvalid && axis_adder_interface_tready;

  assign wbeat_s = '{last: client_last, data: client_data};
  assign rbeat_s = beat_t'(rdata_s);
  assign axis_adder_interface_tdata = rbeat_s.data;
  assign axis_adder_interface_tlast = rbeat_s.last;

  adder_client_fifo #(
    .WIDTH (BEATW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (wbeat_s),
    .pop   (pop_s),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  // Delivered-beat counter and end-of-transaction pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beats_sent_r <= '0;
      txn_done_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        beats_sent_r <= beats_sent_r + CNT_ONE;
      end
      txn_done_r <= pop_s && axis_adder_interface_tlast;
    end
  end

  assign beats_sent = beats_sent_r;
  assign txn_done   = txn_done_r;

endmodule

// File: tb/tb_adder_client.sv
// Directed bench for adder_client; a small scoreboard tracks beats pushed versus beats delivered.
module tb_adder_client;

  localparam int DATAW = 128;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;
  typedef logic [DATAW:0] w_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             client_valid;
  logic [DATAW-1:0] client_data;
  logic             client_last;
  logic             client_ready;
  logic             tvalid;
  logic [DATAW-1:0] tdata;
  logic             tlast;
  logic             tready;
  logic [3:0]       fifo_level;
  logic [CNTW-1:0]  beats_sent;
  logic             txn_done;

  int n_tests = 0;
  int n_fail  = 0;
  w_t exp_q[$];
  logic [CNTW-1:0] exp_sent;
  logic pend_last;

  always #5 clk = ~clk;

  adder_client #(
    .DATAW      (DATAW),
    .FIFO_DEPTH (DEPTH),
    .CNTW       (CNTW)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .client_valid                (client_valid),
    .client_data                 (client_data),
    .client_last                 (client_last),
    .client_ready                (client_ready),
    .axis_adder_interface_tvalid (tvalid),
    .axis_adder_interface_tdata  (tdata),
    .axis_adder_interface_tlast  (tlast),
    .axis_adder_interface_tready (tready),
    .fifo_level                  (fifo_level),
    .beats_sent                  (beats_sent),
    .txn_done                    (txn_done)
  );

  task automatic check_eq(input string tag, input w_t obs, input w_t exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [DATAW-1:0] d, input logic l);
    bit ok = 1'b0;
    client_valid = 1'b1;
    client_data  = d;
    client_last  = l;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (client_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check_eq("push_timeout", w_t'(client_ready), w_t'(1'b1));
    end
  endtask

  task automatic wait_empty(input string tag);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fifo_level == 4'd0) break;
    end
    check_eq(tag, w_t'(fifo_level), w_t'(4'd0));
  endtask

  // Scoreboard: delivered beats must match pushed beats in order; counter and pulse follow pops.
  initial begin
    exp_sent  = '0;
    pend_last = 1'b0;
    forever begin
      @(negedge clk);
      check_eq("mon_done", w_t'(txn_done), w_t'(pend_last));
      check_eq("mon_sent", w_t'(beats_sent), w_t'(exp_sent));
      pend_last = 1'b0;
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check_eq("mon_pop_empty", w_t'(tvalid), w_t'(1'b0));
        end else begin
          check_eq("mon_data", w_t'(tdata), w_t'(exp_q[0][DATAW-1:0]));
          check_eq("mon_last", w_t'(tlast), w_t'(exp_q[0][DATAW]));
          pend_last = exp_q[0][DATAW];
          void'(exp_q.pop_front());
        end
        exp_sent = exp_sent + 4'd1;
      end
      if (client_valid && client_ready) begin
        exp_q.push_back({client_last, client_data});
      end
      if (!rst) begin
        exp_q.delete();
        exp_sent  = '0;
        pend_last = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic a, b, c;
    int   cnt;

    // Reset held with the host already offering data.
    rst = 1'b0; client_valid = 1'b1; client_data = 128'h5A; client_last = 1'b0; tready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_ready", w_t'(client_ready), w_t'(1'b0));
      check_eq("rst_tvalid", w_t'(tvalid), w_t'(1'b0));
      check_eq("rst_level", w_t'(fifo_level), w_t'(4'd0));
      check_eq("rst_sent", w_t'(beats_sent), w_t'(4'd0));
    end
    @(posedge clk); #1;
    rst = 1'b1; client_valid = 1'b0;

    // Basic transaction 1,2,3 with tlast on 3.
    tready = 1'b1;
    client_valid = 1'b1; client_data = 128'd1; client_last = 1'b0;
    @(negedge clk);
    check_eq("bas_pre_tvalid", w_t'(tvalid), w_t'(1'b0));
    check_eq("bas_pre_ready", w_t'(client_ready), w_t'(1'b1));
    @(posedge clk); #1;
    client_valid = 1'b0;
    @(negedge clk);
    check_eq("bas_first_tvalid", w_t'(tvalid), w_t'(1'b1));
    check_eq("bas_first_tdata", w_t'(tdata), w_t'(128'd1));
    check_eq("bas_first_tlast", w_t'(tlast), w_t'(1'b0));
    @(posedge clk); #1;
    push_beat(128'd2, 1'b0);
    push_beat(128'd3, 1'b1);
    client_valid = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (txn_done) cnt++;
    end
    check_eq("bas_done_pulses", w_t'(cnt), w_t'(32'd1));
    check_eq("bas_sent", w_t'(beats_sent), w_t'(4'd3));
    check_eq("bas_level", w_t'(fifo_level), w_t'(4'd0));

    // Backpressure until full, then drain all ten beats.
    @(posedge clk); #1;
    tready = 1'b0;
    for (int i = 0; i < 8; i++) push_beat(128'h100 + 128'(i), 1'b0);
    client_data = 128'h108;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_ready", w_t'(client_ready), w_t'(1'b0));
      check_eq("bp_level", w_t'(fifo_level), w_t'(4'd8));
      check_eq("bp_tdata_hold", w_t'(tdata), w_t'(128'h100));
      check_eq("bp_tvalid", w_t'(tvalid), w_t'(1'b1));
    end
    @(posedge clk); #1;
    tready = 1'b1;
    @(negedge clk);
    check_eq("bp_full_pop_ready", w_t'(client_ready), w_t'(1'b0));
    @(posedge clk); #1;
    push_beat(128'h108, 1'b0);
    push_beat(128'h109, 1'b1);
    client_valid = 1'b0;
    wait_empty("bp_drain");
    check_eq("bp_sent", w_t'(beats_sent), w_t'(4'd13));

    // Steady push and pop at level 4 for 20 cycles.
    @(posedge clk); #1;
    tready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(128'h200 + 128'(i), 1'b0);
    client_valid = 1'b0;
    @(negedge clk);
    check_eq("sim_level_pre", w_t'(fifo_level), w_t'(4'd4));
    @(posedge clk); #1;
    tready = 1'b1; client_valid = 1'b1; client_data = 128'h204;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("sim_level", w_t'(fifo_level), w_t'(4'd4));
      @(posedge clk); #1;
      client_data = 128'h205 + 128'(i);
    end
    client_valid = 1'b0;
    wait_empty("sim_drain");
    check_eq("sim_sent", w_t'(beats_sent), w_t'(4'd5));

    // Reset pulse with five beats buffered.
    @(posedge clk); #1;
    tready = 1'b0;
    for (int i = 0; i < 5; i++) push_beat(128'h300 + 128'(i), 1'b0);
    client_valid = 1'b0;
    @(negedge clk);
    check_eq("mr_level_pre", w_t'(fifo_level), w_t'(4'd5));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mr_ready_in_rst", w_t'(client_ready), w_t'(1'b0));
    check_eq("mr_tvalid_in_rst", w_t'(tvalid), w_t'(1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_level", w_t'(fifo_level), w_t'(4'd0));
    check_eq("mr_tvalid", w_t'(tvalid), w_t'(1'b0));
    check_eq("mr_sent", w_t'(beats_sent), w_t'(4'd0));
    @(posedge clk); #1;
    tready = 1'b1;
    push_beat(128'hABCD, 1'b1);
    client_valid = 1'b0;
    @(negedge clk);
    check_eq("mr_first_tvalid", w_t'(tvalid), w_t'(1'b1));
    check_eq("mr_first_tdata", w_t'(tdata), w_t'(128'hABCD));
    wait_empty("mr_drain");
    check_eq("mr_sent_after", w_t'(beats_sent), w_t'(4'd1));

    // Counter wrap over 18 beats, last two beats both carry tlast.
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 18; i++) push_beat(128'h400 + 128'(i), (i >= 16));
    client_valid = 1'b0;
    @(negedge clk); a = txn_done;
    @(negedge clk); b = txn_done;
    @(negedge clk); c = txn_done;
    check_eq("wrap_done_1", w_t'(a), w_t'(1'b1));
    check_eq("wrap_done_2", w_t'(b), w_t'(1'b1));
    check_eq("wrap_done_3", w_t'(c), w_t'(1'b0));
    check_eq("wrap_sent", w_t'(beats_sent), w_t'(4'd2));
    check_eq("wrap_level", w_t'(fifo_level), w_t'(4'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_client.md
Name: adder_client

Overview:
- Upstream feeder for the adder stage.
- Accepts addends from a host-side valid/ready port and buffers them with their end-of-transaction marker in a synchronous FIFO.
- Drives them onto the adder's AXI-Stream interface (axis_adder_interface_*), obeying the adder's tready backpressure.
- Reports per-transaction completion and a running count of beats delivered.

Parameters:
- DATAW, 128, addend width in bits; must equal the adder's DATAW.
- FIFO_DEPTH, 8, number of buffered beats; power of two, ≥2.
- CNTW, 32, width of the delivered-beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- client_valid  in  1  host presents an addend.
- client_data  in  DATAW  addend value.
- client_last  in  1  addend is the final beat of its transaction.
- client_ready  out  1  block can accept an addend this cycle.
- axis_adder_interface_tvalid  out  1  beat valid toward the adder.
- axis_adder_interface_tdata  out  DATAW  addend toward the adder.
- axis_adder_interface_tlast  out  1  final beat of the transaction.
- axis_adder_interface_tready  in  1  adder accepts the beat.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- beats_sent  out  CNTW  total beats accepted by the adder since reset.
- txn_done  out  1  one-cycle pulse after a tlast beat is accepted.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Read/write pointers, fifo_level, beats_sent and txn_done clear to 0.
  - While rst==0, client_ready=0 and axis_adder_interface_tvalid=0.
  - tdata/tlast are don't-care while tvalid=0.
  - Reset mid-transfer discards all buffered beats; no partial flush.
- Push:
  - Occurs when client_valid && client_ready.
  - {client_last, client_data} is written at the write pointer; the write pointer increments modulo FIFO_DEPTH.
- Pop:
  - Occurs when tvalid && tready; the read pointer increments modulo FIFO_DEPTH.
- Readiness and output:
  - client_ready = rst && (fifo_level != FIFO_DEPTH).
  - Full blocks push even if a pop occurs in the same cycle; there is no full-bypass.
  - tvalid = rst && (fifo_level != 0).
  - tdata/tlast are read combinationally from the head entry (first-word fall-through off registered storage).
- Latency: a beat pushed at edge N is first presented with tvalid=1 in the cycle after edge N; empty-FIFO bypass is not allowed.
- AXI rules:
  - Once tvalid=1, tvalid, tdata and tlast hold stable until a pop occurs.
  - tvalid never depends combinationally on tready.
- fifo_level:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, legal at any level 1..FIFO_DEPTH−1.
  - Empty: a pop is impossible (tvalid=0).
- Pointers use one extra wrap bit, or are derived from fifo_level; full/empty are distinguished without ambiguity at wrap-around.
- beats_sent: +1 on each pop; wraps modulo 2^CNTW with no saturation.
- txn_done: registered; =1 for exactly one cycle after a pop with tlast=1, otherwise 0.
- Back-to-back transactions are allowed: the beat after a tlast beat may be popped on the very next cycle.
- Data is passed unmodified: no arithmetic, no width change.

Decomposition:
- Shared package adder_pkg holds:
  - DATAW=128 as the single system-wide constant.
  - A beat struct {logic last; logic [DATAW-1:0] data} used by the FIFO entries.
- One sub-module: adder_client_fifo, a synchronous FWFT FIFO with parameters WIDTH=DATAW+1 and DEPTH.
  - Ports: push/pop/full/empty/level.
  - Its reset is synchronous active-low.
- adder_client itself holds only the handshake glue, beats_sent and txn_done.

Test Plan:
- Reset: hold rst=0 for 3 cycles with client_valid=1 -> client_ready=0, tvalid=0, fifo_level=0, beats_sent=0 throughout.
- Basic transaction: push addends 1,2,3 (last on 3) with tready=1 constantly -> adder receives 1,2,3 in order, tlast only on 3, first tvalid one cycle after the first push, txn_done pulses once, beats_sent=3.
- Backpressure/full: tready=0, push 10 beats with DEPTH=8 -> client_ready drops after 8, fifo_level=8, and tdata holds the first beat stable. Then raise tready -> remaining 2 beats are accepted as space frees, all 10 delivered in order.
- Simultaneous push/pop: at level 4, assert client_valid and tready for 20 cycles -> level stays 4, 20 beats delivered, pointers wrap cleanly.
- Reset mid-operation: FIFO at level 5 with tready=0; pulse rst=0 for one cycle -> level=0 and tvalid=0 next cycle; the next pushed beat (0xABCD) is the first delivered.
- Counter wrap (CNTW=4): deliver 18 beats -> beats_sent=2; two tlast beats back-to-back -> txn_done high on two consecutive cycles.
